// File: rtl/bin_to_digit_pkg.sv
// Shared constants, state encoding and request type for the binary-to-display-digit converter.
package bin_to_digit_pkg;

  localparam logic [3:0] DIG_BLANK  = 4'd10;
  localparam logic [3:0] DIG_MINUS  = 4'd11;
  localparam int         BIN_W      = 20;
  localparam int         BCD_DIGITS = 7;
  localparam int         BCD_W      = BCD_DIGITS * 4;
  localparam int         CONV_STEPS = 20;
  localparam int         CNT_W      = $clog2(CONV_STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FMT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [BIN_W-1:0] mag;
    logic             neg;
  } conv_req_t;

endpackage

// File: rtl/bin_to_digit_nibble_adj.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more.
module bcd_nibble_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_digit.sv
// Serial double-dabble conversion of a 20-bit magnitude into eight display codes,
// with optional leading-zero blanking and a floating minus sign.
module bin_to_digit
  import bin_to_digit_pkg::*;
#(
  parameter bit BLANK_EN = 1'b1
) (
  input  logic             sclk,
  input  logic             nrst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  input  logic             neg,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bit_7,
  output logic [3:0]       bit_6,
  output logic [3:0]       bit_5,
  output logic [3:0]       bit_4,
  output logic [3:0]       bit_3,
  output logic [3:0]       bit_2,
  output logic [3:0]       bit_1,
  output logic [3:0]       bit_0
);

  state_t           state, state_nxt;
  conv_req_t        req;
  logic [BCD_W-1:0] bcd, bcd_adj;
  logic [BIN_W-1:0] shreg;
  logic             neg_q;
  logic [CNT_W-1:0] cnt;
  logic [7:0][3:0]  disp_q, disp_nxt;
  int               msd;
  logic             nz;

  assign req = '{mag: bin, neg: neg};

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_nibble_adj u_adj (
      .din  (bcd[g*4 +: 4]),
      .dout (bcd_adj[g*4 +: 4])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (cnt == CNT_W'(CONV_STEPS - 1)) state_nxt = FMT;
      FMT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Minus sits just left of the most significant shown digit; zero never gets one.
  always_comb begin
    msd = 0;
    for (int i = 1; i < BCD_DIGITS; i++)
      if (bcd[i*4 +: 4] != 4'd0) msd = i;
    nz = |bcd;
    disp_nxt    = '0;
    disp_nxt[7] = (neg_q && nz) ? DIG_MINUS : DIG_BLANK;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      disp_nxt[i] = bcd[i*4 +: 4];
      if (BLANK_EN && i > msd)
        disp_nxt[i] = (neg_q && nz && i == msd + 1) ? DIG_MINUS : DIG_BLANK;
    end
    if (BLANK_EN && msd != BCD_DIGITS - 1) disp_nxt[7] = DIG_BLANK;
  end

  always_ff @(posedge sclk) begin
    if (!nrst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      bcd    <= '0;
      shreg  <= '0;
      neg_q  <= 1'b0;
      disp_q <= {8{DIG_BLANK}};
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          shreg <= req.mag;
          neg_q <= req.neg;
          bcd   <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        CONV: begin
          bcd   <= {bcd_adj[BCD_W-2:0], shreg[BIN_W-1]};
          shreg <= {shreg[BIN_W-2:0], 1'b0};
          cnt   <= cnt + CNT_W'(1);
        end
        FMT: begin
          disp_q <= disp_nxt;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bit_7 = disp_q[7];
  assign bit_6 = disp_q[6];
  assign bit_5 = disp_q[5];
  assign bit_4 = disp_q[4];
  assign bit_3 = disp_q[3];
  assign bit_2 = disp_q[2];
  assign bit_1 = disp_q[1];
  assign bit_0 = disp_q[0];

endmodule
